// File: rtl/lanectrl_dly_pkg.sv
// +---------------------------------------------------------------------------+
// | lanectrl_dly_pkg : shared state type, status codes and parameter defaults |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package lanectrl_dly_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PAUSE  = 3'd1,
    S_PULSE  = 3'd2,
    S_SETTLE = 3'd3,
    S_RESUME = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_OOR   = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;

  localparam int DEF_STEP_W        = 9;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_PAUSE_LEAD    = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lanectrl_dly_timer.sv
// +---------------------------------------------------------------------------+
// | lanectrl_dly_timer : loadable down-counter, tc high while count is zero   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module lanectrl_dly_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign tc = (count == '0);

endmodule

`default_nettype wire

// File: rtl/lanectrl_dly_step_ctrl.sv
// +---------------------------------------------------------------------------+
// | lanectrl_dly_step_ctrl : LANECTRL delay-line tap sequencer (FAB_CLK)      |
// | Option macro LANECTRL_DLY_PAUSE_EN enables HS_IO_CLK_PAUSE lead/trail.    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module lanectrl_dly_step_ctrl
  import lanectrl_dly_pkg::*;
#(
  parameter int STEP_W        = DEF_STEP_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int PAUSE_LEAD    = DEF_PAUSE_LEAD
) (
  input  logic              FAB_CLK,
  input  logic              RESET_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_SEL,
  input  logic              REQ_DIR,
  input  logic              REQ_LOAD,
  input  logic [STEP_W-1:0] REQ_STEPS,
  input  logic              ABORT,
  output logic              DONE,
  output logic [1:0]        DONE_STATUS,
  output logic [STEP_W-1:0] STEPS_DONE,
  output logic              DELAY_LINE_SEL,
  output logic              DELAY_LINE_DIRECTION,
  output logic              DELAY_LINE_MOVE,
  output logic              DELAY_LINE_LOAD,
  output logic              HS_IO_CLK_PAUSE,
  input  logic              RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic              TX_DELAY_LINE_OUT_OF_RANGE
);

`ifdef LANECTRL_DLY_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int                TMR_W     = $clog2(max_int(SETTLE_CYCLES, PAUSE_LEAD) + 1);
  localparam logic [TMR_W-1:0]  SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LEAD_LD   = TMR_W'(PAUSE_LEAD - 1);
  localparam logic [STEP_W-1:0] ONE_STEP  = STEP_W'(1);

  state_e             state;
  state_e             next_state;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_tc;
  logic [STEP_W-1:0]  steps_left;
  logic               load_req;
  logic               oor_sel;
  logic               accept;
  logic               pulse_is_load;
  logic               ready_d;
  logic               done_d;
  logic               move_d;
  logic               load_d;
  logic               pause_d;

  assign accept        = (state == S_IDLE) && REQ_VALID;
  assign oor_sel       = DELAY_LINE_SEL ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
  // The first pulse can follow accept directly, before load_req has been captured.
  assign pulse_is_load = (state == S_IDLE) ? REQ_LOAD : load_req;

  lanectrl_dly_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (FAB_CLK),
    .rst_n    (RESET_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge FAB_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = SETTLE_LD;
    case (state)
      S_IDLE: begin
        if (REQ_VALID) begin
          if (!REQ_LOAD && (REQ_STEPS == '0)) begin
            next_state = S_DONE;
          end else if (PAUSE_EN) begin
            next_state = S_PAUSE;
            tmr_load   = 1'b1;
            tmr_val    = LEAD_LD;
          end else begin
            next_state = S_PULSE;
          end
        end
      end
      S_PAUSE: begin
        if (tmr_tc) next_state = S_PULSE;
      end
      S_PULSE: begin
        next_state = S_SETTLE;
        tmr_load   = 1'b1;
        tmr_val    = SETTLE_LD;
      end
      S_SETTLE: begin
        if (tmr_tc) begin
          if (oor_sel || ABORT || (steps_left == '0)) begin
            if (PAUSE_EN) begin
              next_state = S_RESUME;
              tmr_load   = 1'b1;
              tmr_val    = LEAD_LD;
            end else begin
              next_state = S_DONE;
            end
          end else begin
            next_state = S_PULSE;
          end
        end
      end
      S_RESUME: begin
        if (tmr_tc) next_state = S_DONE;
      end
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered so the pins are glitch-free.
  always_comb begin
    ready_d = (next_state == S_IDLE);
    done_d  = (next_state == S_DONE);
    move_d  = (next_state == S_PULSE) && !pulse_is_load;
    load_d  = (next_state == S_PULSE) && pulse_is_load;
    pause_d = PAUSE_EN && (next_state inside {S_PAUSE, S_PULSE, S_SETTLE});
  end

  always_ff @(posedge FAB_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      REQ_READY       <= 1'b1;
      DONE            <= 1'b0;
      DELAY_LINE_MOVE <= 1'b0;
      DELAY_LINE_LOAD <= 1'b0;
      HS_IO_CLK_PAUSE <= 1'b0;
    end else begin
      REQ_READY       <= ready_d;
      DONE            <= done_d;
      DELAY_LINE_MOVE <= move_d;
      DELAY_LINE_LOAD <= load_d;
      HS_IO_CLK_PAUSE <= pause_d;
    end
  end

  always_ff @(posedge FAB_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      DELAY_LINE_SEL       <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
      load_req             <= 1'b0;
      steps_left           <= '0;
      STEPS_DONE           <= '0;
      DONE_STATUS          <= ST_OK;
    end else begin
      if (accept) begin
        DELAY_LINE_SEL       <= REQ_SEL;
        DELAY_LINE_DIRECTION <= REQ_DIR;
        load_req             <= REQ_LOAD;
        steps_left           <= REQ_LOAD ? ONE_STEP : REQ_STEPS;
        STEPS_DONE           <= '0;
        DONE_STATUS          <= ST_OK;
      end
      if (state == S_PULSE) begin
        steps_left <= steps_left - ONE_STEP;
        STEPS_DONE <= STEPS_DONE + ONE_STEP;
      end
      // Out-of-range outranks abort at the settle sample point.
      if ((state == S_SETTLE) && tmr_tc) begin
        if (oor_sel) begin
          DONE_STATUS <= ST_OOR;
        end else if (ABORT) begin
          DONE_STATUS <= ST_ABORT;
        end
      end
    end
  end

endmodule

`default_nettype wire
